// File: rtl/scenario_loader_pkg.sv
// Shared types and record-layout helpers for the scenario loader.
// Record layout: loc[0..D-1], velo[0..D-1], mass, radius; every field is sent MSB first.
package loader_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        PAYLOAD,
        CHECK
    } state_e;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    function automatic int record_bytes(input int width, input int dims);
        return 2 * dims * width / 8 + width / 16 + 1;
    endfunction

    function automatic int velo_offset(input int width, input int dims);
        return dims * width / 8;
    endfunction

    function automatic int mass_offset(input int width, input int dims);
        return 2 * dims * width / 8;
    endfunction

    function automatic int radius_offset(input int width, input int dims);
        return 2 * dims * width / 8 + width / 16;
    endfunction

endpackage

// File: rtl/scenario_loader_if.sv
// Byte-stream handshake from the host link into the scenario loader.
interface scenario_loader_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;

    modport master (output rx_data, output rx_valid, input rx_ready);
    modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/scenario_loader_record_assembler.sv
// Shadow record storage: tracks the byte position inside a record, decodes which
// field it belongs to and shifts the byte MSB-first into the selected sprite's shadow.
module record_assembler
    import loader_pkg::*;
#(
    parameter int SPRITES    = 9,
    parameter int WIDTH      = 32,
    parameter int DIMENSIONS = 2,
    parameter int IDX_W      = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear_i,
    input  logic                 byte_en_i,
    input  logic [7:0]           byte_i,
    input  logic [IDX_W-1:0]     sprite_idx_i,
    output logic                 last_byte_o,
    output logic [WIDTH-1:0]     loc_o    [SPRITES][DIMENSIONS],
    output logic [WIDTH-1:0]     velo_o   [SPRITES][DIMENSIONS],
    output logic [WIDTH/2-1:0]   mass_o   [SPRITES],
    output logic [6:0]           radius_o [SPRITES]
);
    localparam int REC_BYTES   = record_bytes(WIDTH, DIMENSIONS);
    localparam int FIELD_BYTES = WIDTH / 8;
    localparam int VELO_OFF    = velo_offset(WIDTH, DIMENSIONS);
    localparam int MASS_OFF    = mass_offset(WIDTH, DIMENSIONS);
    localparam int RADIUS_OFF  = radius_offset(WIDTH, DIMENSIONS);
    localparam int BI_W        = $clog2(REC_BYTES);
    localparam int MASS_W      = WIDTH / 2;

    logic [BI_W-1:0]       byte_idx_q, byte_idx_d;
    logic [DIMENSIONS-1:0] loc_hit, velo_hit;
    logic                  mass_hit, radius_hit;

    assign last_byte_o = (byte_idx_q == BI_W'(REC_BYTES - 1));

    always_comb begin
        for (int d = 0; d < DIMENSIONS; d++) begin
            loc_hit[d]  = (int'(byte_idx_q) >= d * FIELD_BYTES) &&
                          (int'(byte_idx_q) <  (d + 1) * FIELD_BYTES);
            velo_hit[d] = (int'(byte_idx_q) >= VELO_OFF + d * FIELD_BYTES) &&
                          (int'(byte_idx_q) <  VELO_OFF + (d + 1) * FIELD_BYTES);
        end
        mass_hit   = (int'(byte_idx_q) >= MASS_OFF) && (int'(byte_idx_q) < RADIUS_OFF);
        radius_hit = (int'(byte_idx_q) == RADIUS_OFF);
    end

    always_comb begin
        byte_idx_d = byte_idx_q;
        if (clear_i) begin
            byte_idx_d = '0;
        end else if (byte_en_i) begin
            byte_idx_d = last_byte_o ? '0 : byte_idx_q + BI_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_idx_q <= '0;
        end else begin
            byte_idx_q <= byte_idx_d;
        end
    end

    for (genvar gi = 0; gi < SPRITES; gi++) begin : g_sprite
        logic [WIDTH-1:0]  loc_q  [DIMENSIONS];
        logic [WIDTH-1:0]  velo_q [DIMENSIONS];
        logic [MASS_W-1:0] mass_q;
        logic [6:0]        radius_q;
        logic              sel;

        assign sel = byte_en_i && (sprite_idx_i == IDX_W'(gi));

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int d = 0; d < DIMENSIONS; d++) begin
                    loc_q[d]  <= '0;
                    velo_q[d] <= '0;
                end
                mass_q   <= '0;
                radius_q <= '0;
            end else if (clear_i) begin
                for (int d = 0; d < DIMENSIONS; d++) begin
                    loc_q[d]  <= '0;
                    velo_q[d] <= '0;
                end
                mass_q   <= '0;
                radius_q <= '0;
            end else if (sel) begin
                for (int d = 0; d < DIMENSIONS; d++) begin
                    if (loc_hit[d])  loc_q[d]  <= (loc_q[d]  << 8) | WIDTH'(byte_i);
                    if (velo_hit[d]) velo_q[d] <= (velo_q[d] << 8) | WIDTH'(byte_i);
                end
                if (mass_hit)   mass_q   <= (mass_q << 8) | MASS_W'(byte_i);
                // Bit 7 of the radius byte is dropped here; it still feeds the checksum upstream.
                if (radius_hit) radius_q <= byte_i[6:0];
            end
        end

        for (genvar gd = 0; gd < DIMENSIONS; gd++) begin : g_dim
            assign loc_o[gi][gd]  = loc_q[gd];
            assign velo_o[gi][gd] = velo_q[gd];
        end
        assign mass_o[gi]   = mass_q;
        assign radius_o[gi] = radius_q;
    end

endmodule

// File: rtl/scenario_loader.sv
// Framed scenario loader: SYNC, COUNT, N records, CHK; commits shadow records atomically on a good checksum.
// Optional inter-byte timeout enabled by defining LOADER_TIMEOUT_EN.
module scenario_loader
    import loader_pkg::*;
#(
    parameter int SPRITES    = 9,
    parameter int WIDTH      = 32,
    parameter int DIMENSIONS = 2,
    parameter int TIMEOUT    = 1_620_000
) (
    input  logic               clk_162,
    input  logic               rst_l,
    scenario_loader_if.slave   rx,
    output logic [WIDTH-1:0]   init_locations [SPRITES][DIMENSIONS],
    output logic [WIDTH-1:0]   init_velos     [SPRITES][DIMENSIONS],
    output logic [WIDTH/2-1:0] masses         [SPRITES],
    output logic [6:0]         radii          [SPRITES],
    output logic               data_ready,
    output logic               load_error,
    output logic               busy
);
    localparam int CNT_W = $clog2(SPRITES + 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] sprite_q, sprite_d;
    logic [7:0]       xor_q, xor_d;
    logic             data_ready_q, data_ready_d;
    logic             load_error_q, load_error_d;
    logic             rx_ready_int, accept, clear, byte_en, commit, last_byte, timeout_hit;

    logic [WIDTH-1:0]   shadow_loc  [SPRITES][DIMENSIONS];
    logic [WIDTH-1:0]   shadow_velo [SPRITES][DIMENSIONS];
    logic [WIDTH/2-1:0] shadow_mass [SPRITES];
    logic [6:0]         shadow_rad  [SPRITES];

    logic [WIDTH-1:0]   init_loc_q  [SPRITES][DIMENSIONS];
    logic [WIDTH-1:0]   init_velo_q [SPRITES][DIMENSIONS];
    logic [WIDTH/2-1:0] mass_q      [SPRITES];
    logic [6:0]         rad_q       [SPRITES];

    // Stall for the single strobe cycle so a back-to-back SYNC lands one cycle later.
    assign rx_ready_int = ~(data_ready_q | load_error_q);
    assign rx.rx_ready  = rx_ready_int;
    assign accept       = rx.rx_valid & rx_ready_int;

    record_assembler #(
        .SPRITES    (SPRITES),
        .WIDTH      (WIDTH),
        .DIMENSIONS (DIMENSIONS),
        .IDX_W      (CNT_W)
    ) u_assembler (
        .clk          (clk_162),
        .rst_n        (rst_l),
        .clear_i      (clear),
        .byte_en_i    (byte_en),
        .byte_i       (rx.rx_data),
        .sprite_idx_i (sprite_q),
        .last_byte_o  (last_byte),
        .loc_o        (shadow_loc),
        .velo_o       (shadow_velo),
        .mass_o       (shadow_mass),
        .radius_o     (shadow_rad)
    );

`ifdef LOADER_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT);

    logic [TMR_W-1:0] timer_q, timer_d;

    assign timeout_hit = (timer_q == TMR_W'(TIMEOUT - 1));

    always_comb begin
        timer_d = timer_q + TMR_W'(1);
        if (state_q == IDLE || accept || timeout_hit) begin
            timer_d = '0;
        end
    end

    always_ff @(posedge clk_162 or negedge rst_l) begin
        if (!rst_l) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        sprite_d     = sprite_q;
        xor_d        = xor_q;
        data_ready_d = 1'b0;
        load_error_d = 1'b0;
        clear        = 1'b0;
        byte_en      = 1'b0;
        commit       = 1'b0;
        if (timeout_hit) begin
            load_error_d = 1'b1;
            state_d      = IDLE;
        end else if (accept) begin
            unique case (state_q)
                IDLE: begin
                    if (rx.rx_data == SYNC_BYTE) begin
                        clear   = 1'b1;
                        xor_d   = '0;
                        state_d = COUNT;
                    end
                end
                COUNT: begin
                    if (rx.rx_data != 8'd0 && rx.rx_data <= 8'(SPRITES)) begin
                        count_d  = rx.rx_data[CNT_W-1:0];
                        sprite_d = '0;
                        xor_d    = rx.rx_data;
                        state_d  = PAYLOAD;
                    end else begin
                        load_error_d = 1'b1;
                        state_d      = IDLE;
                    end
                end
                PAYLOAD: begin
                    byte_en = 1'b1;
                    xor_d   = xor_q ^ rx.rx_data;
                    if (last_byte) begin
                        sprite_d = sprite_q + CNT_W'(1);
                        if (sprite_q + CNT_W'(1) == count_q) state_d = CHECK;
                    end
                end
                CHECK: begin
                    if (rx.rx_data == xor_q) begin
                        commit       = 1'b1;
                        data_ready_d = 1'b1;
                    end else begin
                        load_error_d = 1'b1;
                    end
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_162 or negedge rst_l) begin
        if (!rst_l) begin
            state_q      <= IDLE;
            count_q      <= '0;
            sprite_q     <= '0;
            xor_q        <= '0;
            data_ready_q <= 1'b0;
            load_error_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            sprite_q     <= sprite_d;
            xor_q        <= xor_d;
            data_ready_q <= data_ready_d;
            load_error_q <= load_error_d;
        end
    end

    // Whole scenario copied in one edge, together with the rise of data_ready.
    always_ff @(posedge clk_162 or negedge rst_l) begin
        if (!rst_l) begin
            for (int s = 0; s < SPRITES; s++) begin
                for (int d = 0; d < DIMENSIONS; d++) begin
                    init_loc_q[s][d]  <= '0;
                    init_velo_q[s][d] <= '0;
                end
                mass_q[s] <= '0;
                rad_q[s]  <= '0;
            end
        end else if (commit) begin
            init_loc_q  <= shadow_loc;
            init_velo_q <= shadow_velo;
            mass_q      <= shadow_mass;
            rad_q       <= shadow_rad;
        end
    end

    assign init_locations = init_loc_q;
    assign init_velos     = init_velo_q;
    assign masses         = mass_q;
    assign radii          = rad_q;
    assign data_ready     = data_ready_q;
    assign load_error     = load_error_q;
    assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_scenario_loader.sv
// Scoreboard bench for scenario_loader: expected strobes and output snapshots are queued
// by the stimulus and checked by a monitor whenever data_ready or load_error fires.
`timescale 1ns/1ps
module tb_scenario_loader;
    localparam int S = 9;
    localparam int D = 2;
    localparam int W = 32;

    typedef struct packed {
        logic                         is_commit;
        logic [S-1:0][D-1:0][W-1:0]   loc;
        logic [S-1:0][D-1:0][W-1:0]   velo;
        logic [S-1:0][W/2-1:0]        mass;
        logic [S-1:0][6:0]            rad;
    } exp_t;

    logic clk = 1'b0;
    logic rst_l = 1'b0;
    always #5 clk = ~clk;

    scenario_loader_if rx_if();

    logic [W-1:0]   init_locations [S][D];
    logic [W-1:0]   init_velos     [S][D];
    logic [W/2-1:0] masses         [S];
    logic [6:0]     radii          [S];
    logic           data_ready, load_error, busy;

    scenario_loader #(
        .SPRITES    (S),
        .WIDTH      (W),
        .DIMENSIONS (D),
        .TIMEOUT    (100)
    ) dut (
        .clk_162        (clk),
        .rst_l          (rst_l),
        .rx             (rx_if),
        .init_locations (init_locations),
        .init_velos     (init_velos),
        .masses         (masses),
        .radii          (radii),
        .data_ready     (data_ready),
        .load_error     (load_error),
        .busy           (busy)
    );

    int total_cnt = 0;
    int pass_cnt  = 0;
    int stalls    = 0;
    int cyc       = 0;
    int last_acc_cyc = 0;
    int strobe_cyc   = 0;
    logic [7:0] tb_xor = 8'h00;
    exp_t cur, nxt;
    exp_t sb_q[$];

    logic [7:0] f1 [22] = '{8'hA5, 8'h01,
                            8'h00, 8'h01, 8'h00, 8'h00,
                            8'h00, 8'h02, 8'h00, 8'h00,
                            8'hFF, 8'hFF, 8'h00, 8'h00,
                            8'h00, 8'h00, 8'h00, 8'h00,
                            8'h0C, 8'h00, 8'h8A, 8'h84};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    endtask

    task automatic compare_outputs(input exp_t e);
        chk("strobe_kind", 64'({data_ready, load_error}), e.is_commit ? 64'd2 : 64'd1);
        for (int s = 0; s < S; s++) begin
            for (int d = 0; d < D; d++) begin
                chk($sformatf("loc[%0d][%0d]", s, d), 64'(init_locations[s][d]), 64'(e.loc[s][d]));
                chk($sformatf("velo[%0d][%0d]", s, d), 64'(init_velos[s][d]), 64'(e.velo[s][d]));
            end
            chk($sformatf("mass[%0d]", s), 64'(masses[s]), 64'(e.mass[s]));
            chk($sformatf("radius[%0d]", s), 64'(radii[s]), 64'(e.rad[s]));
        end
    endtask

    // Monitor: every strobe cycle consumes one queued expectation.
    always @(negedge clk) begin
        if (rst_l && (data_ready || load_error)) begin
            strobe_cyc = cyc;
            chk("rx_ready_low_in_strobe", 64'(rx_if.rx_ready), 64'd0);
            if (sb_q.size() == 0) begin
                chk("unexpected_strobe", 64'({data_ready, load_error}), 64'd0);
            end else begin
                compare_outputs(sb_q.pop_front());
            end
        end
    end

    task automatic nonzero_outputs(output int n);
        n = 0;
        for (int s = 0; s < S; s++) begin
            for (int d = 0; d < D; d++) begin
                if (init_locations[s][d] != '0) n++;
                if (init_velos[s][d] != '0) n++;
            end
            if (masses[s] != '0) n++;
            if (radii[s] != '0) n++;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int guard = 0;
        rx_if.rx_data  = b;
        rx_if.rx_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (rx_if.rx_ready) break;
            stalls++;
            guard++;
            if (guard > 20) begin
                chk("rx_accept_timeout", 64'd0, 64'd1);
                break;
            end
        end
        @(posedge clk);
        #1;
        tb_xor ^= b;
        last_acc_cyc   = cyc;
        rx_if.rx_valid = 1'b0;
    endtask

    task automatic send32(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
    endtask

    task automatic send_rec(input logic [31:0] l0, input logic [31:0] l1, input logic [31:0] v0,
                            input logic [31:0] v1, input logic [15:0] m, input logic [7:0] r);
        send32(l0); send32(l1); send32(v0); send32(v1);
        send_byte(m[15:8]); send_byte(m[7:0]); send_byte(r);
    endtask

    task automatic start_frame(input logic [7:0] n);
        send_byte(8'hA5);
        tb_xor = 8'h00;
        send_byte(n);
    endtask

    initial begin
        int nz;
        rx_if.rx_valid = 1'b0;
        rx_if.rx_data  = 8'h00;
        cur = '0;

        repeat (3) @(posedge clk);
        #1;
        nonzero_outputs(nz);
        chk("reset_outputs_zero", 64'(nz), 64'd0);
        chk("reset_data_ready", 64'(data_ready), 64'd0);
        chk("reset_load_error", 64'(load_error), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_rx_ready", 64'(rx_if.rx_ready), 64'd1);
        @(negedge clk) rst_l = 1'b1;
        @(posedge clk);
        #1;

        // Single-sprite frame with hand-computed checksum 0x84.
        nxt = '0;
        nxt.is_commit    = 1'b1;
        nxt.loc[0][0]    = 32'h0001_0000;
        nxt.loc[0][1]    = 32'h0002_0000;
        nxt.velo[0][0]   = 32'hFFFF_0000;
        nxt.mass[0]      = 16'h0C00;
        nxt.rad[0]       = 7'h0A;
        sb_q.push_back(nxt);
        cur = nxt;
        for (int i = 0; i < 22; i++) begin
            send_byte(f1[i]);
            if (i == 2) chk("busy_in_payload", 64'(busy), 64'd1);
        end

        // Back-to-back SYNC stalls one cycle; corrupted CHK keeps prior outputs.
        nxt = cur;
        nxt.is_commit = 1'b0;
        sb_q.push_back(nxt);
        stalls = 0;
        send_byte(f1[0]);
        chk("b2b_sync_stall", 64'(stalls), 64'd1);
        for (int i = 1; i < 21; i++) send_byte(f1[i]);
        send_byte(f1[21] ^ 8'h01);

        // Illegal counts.
        sb_q.push_back(nxt);
        send_byte(8'hA5);
        chk("busy_in_count", 64'(busy), 64'd1);
        send_byte(8'h00);
        chk("idle_after_count0", 64'(busy), 64'd0);
        sb_q.push_back(nxt);
        send_byte(8'hA5);
        send_byte(8'h0A);
        chk("idle_after_count10", 64'(busy), 64'd0);

        cur.is_commit = 1'b1;
        sb_q.push_back(cur);
        for (int i = 0; i < 22; i++) send_byte(f1[i]);

        // Noise then a full nine-sprite frame with 0xA5 inside velocity data.
        repeat (3) @(posedge clk);
        #1;
        stalls = 0;
        send_byte(8'h00); send_byte(8'hFF); send_byte(8'h3C);
        chk("noise_stays_idle", 64'(busy), 64'd0);
        nxt = '0;
        nxt.is_commit = 1'b1;
        for (int s = 0; s < S; s++) begin
            nxt.loc[s][0]  = 32'h1000_0000 + 32'(s);
            nxt.loc[s][1]  = 32'h0200_0000 | (32'(s) << 8);
            nxt.velo[s][0] = 32'hA5A5_0000 | 32'(s);
            nxt.velo[s][1] = 32'hFFFF_FF00 | 32'(s);
            nxt.mass[s]    = 16'h0100 + 16'(s);
            nxt.rad[s]     = 7'h10 + 7'(s);
        end
        sb_q.push_back(nxt);
        cur = nxt;
        start_frame(8'd9);
        for (int s = 0; s < S; s++) begin
            send_rec(nxt.loc[s][0], nxt.loc[s][1], nxt.velo[s][0], nxt.velo[s][1],
                     nxt.mass[s], {1'b1, nxt.rad[s]});
        end
        send_byte(tb_xor);
        chk("frame9_no_stall", 64'(stalls), 64'd0);

        // Asynchronous reset in the middle of sprite 2's record.
        repeat (2) @(posedge clk);
        #1;
        start_frame(8'd3);
        send_rec(32'hDEAD_BEEF, 32'h1234_5678, 32'h0BAD_F00D, 32'h5555_AAAA, 16'h7777, 8'h11);
        send_rec(32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 32'h0000_0004, 16'h0005, 8'h06);
        for (int i = 0; i < 7; i++) send_byte(8'h42);
        #2 rst_l = 1'b0;
        #1;
        nonzero_outputs(nz);
        chk("midframe_reset_outputs_zero", 64'(nz), 64'd0);
        chk("midframe_reset_busy", 64'(busy), 64'd0);
        chk("midframe_reset_data_ready", 64'(data_ready), 64'd0);
        cur = '0;
        @(negedge clk) rst_l = 1'b1;
        @(posedge clk);
        #1;

        nxt = '0;
        nxt.is_commit  = 1'b1;
        nxt.loc[0][0]  = 32'h1111_1111; nxt.loc[0][1]  = 32'h2222_2222;
        nxt.velo[0][0] = 32'h3333_3333; nxt.velo[0][1] = 32'h4444_4444;
        nxt.mass[0]    = 16'h5555;      nxt.rad[0]     = 7'h7F;
        nxt.loc[1][0]  = 32'h0102_0304; nxt.loc[1][1]  = 32'h0506_0708;
        nxt.velo[1][0] = 32'h090A_0B0C; nxt.velo[1][1] = 32'h0D0E_0F10;
        nxt.mass[1]    = 16'h1112;      nxt.rad[1]     = 7'h13;
        sb_q.push_back(nxt);
        cur = nxt;
        start_frame(8'd2);
        send_rec(32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444, 16'h5555, 8'hFF);
        send_rec(32'h0102_0304, 32'h0506_0708, 32'h090A_0B0C, 32'h0D0E_0F10, 16'h1112, 8'h13);
        send_byte(tb_xor);

`ifdef LOADER_TIMEOUT_EN
        repeat (2) @(posedge clk);
        #1;
        nxt = cur;
        nxt.is_commit = 1'b0;
        sb_q.push_back(nxt);
        start_frame(8'd1);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
        for (int i = 0; i < 300 && sb_q.size() != 0; i++) @(posedge clk);
        chk("timeout_latency", 64'(strobe_cyc - last_acc_cyc), 64'd100);
`endif

        for (int i = 0; i < 300 && sb_q.size() != 0; i++) @(posedge clk);
        repeat (5) @(posedge clk);
        #1;
        chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        chk("final_idle", 64'(busy), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
